// File: rtl/fir_mac_engine.sv
// Streaming FIR multiply-accumulate engine: consumes paired sample/coefficient words,
// emits one shifted, saturated 32-bit result per len taps, nb_iter results per job.
module fir_mac_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [CNT_W-1:0]  nb_iter_i,
  input  logic [4:0]        shift_i,
  input  logic              simple_mul_i,
  input  logic              x_valid_i,
  output logic              x_ready_o,
  input  logic [DATA_W-1:0] x_data_i,
  input  logic              h_valid_i,
  output logic              h_ready_o,
  input  logic [DATA_W-1:0] h_data_i,
  output logic              y_valid_o,
  input  logic              y_ready_i,
  output logic [31:0]       y_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {StIdle, StAccum, StOutput, StDone} state_e;

  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

  state_e                    state_q;
  logic [CNT_W-1:0]          len_q, nb_iter_q, tap_q, iter_q;
  logic [4:0]                shift_q;
  logic                      simple_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      y_valid_q, busy_q, done_q;
  logic [31:0]               y_data_q;

  logic                      in_accum, fire, last_tap, more_iter;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext, acc_sum, acc_shr;
  logic [CNT_W-1:0]          eff_len, tap_inc, iter_inc;
  logic [31:0]               sat_res;

  // A clear cycle must not consume a word, so readiness is withheld while clear_i is high.
  assign in_accum  = (state_q == StAccum) && !clear_i;
  assign x_ready_o = in_accum & h_valid_i;
  assign h_ready_o = in_accum & x_valid_i;
  assign fire      = in_accum & x_valid_i & h_valid_i;

  assign y_valid_o = y_valid_q;
  assign y_data_o  = y_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  always_comb begin
    prod      = $signed(x_data_i) * $signed(h_data_i);
    prod_ext  = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    acc_sum   = acc_q + prod_ext;
    // Arithmetic shift sign-fills, so large shifts settle at 0 or -1.
    acc_shr   = acc_sum >>> shift_q;
    if (acc_shr > SatMax) begin
      sat_res = 32'h7fff_ffff;
    end else if (acc_shr < SatMin) begin
      sat_res = 32'h8000_0000;
    end else begin
      sat_res = acc_shr[31:0];
    end
    eff_len   = (simple_q || (len_q == '0)) ? CNT_W'(1) : len_q;
    tap_inc   = tap_q + CNT_W'(1);
    iter_inc  = iter_q + CNT_W'(1);
    last_tap  = (tap_inc == eff_len);
    more_iter = (iter_inc < nb_iter_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      nb_iter_q <= '0;
      shift_q   <= '0;
      simple_q  <= 1'b0;
      acc_q     <= '0;
      tap_q     <= '0;
      iter_q    <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      nb_iter_q <= '0;
      shift_q   <= '0;
      simple_q  <= 1'b0;
      acc_q     <= '0;
      tap_q     <= '0;
      iter_q    <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q     <= len_i;
            nb_iter_q <= nb_iter_i;
            shift_q   <= shift_i;
            simple_q  <= simple_mul_i;
            acc_q     <= '0;
            tap_q     <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b1;
            if (nb_iter_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (fire) begin
            acc_q <= acc_sum;
            tap_q <= tap_inc;
            if (last_tap) begin
              y_data_q  <= sat_res;
              y_valid_q <= 1'b1;
              state_q   <= StOutput;
            end
          end
        end
        StOutput: begin
          if (y_ready_i) begin
            y_valid_q <= 1'b0;
            iter_q    <= iter_inc;
            acc_q     <= '0;
            tap_q     <= '0;
            if (more_iter) begin
              state_q <= StAccum;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: an arithmetic reference model predicts every result,
// a negedge monitor checks each output handshake, and literal pins anchor the model.
module tb_fir_mac_engine;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 12;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              clear_i = 1'b0;
  logic              start_i = 1'b0;
  logic [CNT_W-1:0]  len_i = '0;
  logic [CNT_W-1:0]  nb_iter_i = '0;
  logic [4:0]        shift_i = '0;
  logic              simple_mul_i = 1'b0;
  logic              x_valid_i = 1'b0;
  logic              x_ready_o;
  logic [DATA_W-1:0] x_data_i = '0;
  logic              h_valid_i = 1'b0;
  logic              h_ready_o;
  logic [DATA_W-1:0] h_data_i = '0;
  logic              y_valid_o;
  logic              y_ready_i = 1'b1;
  logic [31:0]       y_data_o;
  logic              busy_o;
  logic              done_o;

  fir_mac_engine dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .len_i(len_i), .nb_iter_i(nb_iter_i), .shift_i(shift_i), .simple_mul_i(simple_mul_i),
    .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_data_i(x_data_i),
    .h_valid_i(h_valid_i), .h_ready_o(h_ready_o), .h_data_i(h_data_i),
    .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .y_data_o(y_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          xq[$];
  int          hq[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: each output is the dot product of its eff taps, shifted then clamped to int32.
  task automatic model(input int len, input int nb, input int sh, input bit simple);
    int eff;
    longint acc;
    eff = (simple || len == 0) ? 1 : len;
    for (int k = 0; k < nb; k++) begin
      acc = 0;
      for (int j = 0; j < eff; j++) acc += longint'(xq[k*eff+j]) * longint'(hq[k*eff+j]);
      acc = acc >>> sh;
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
      exp_q.push_back(acc[31:0]);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) done_cnt++;
      if (y_valid_o) check("no_accum_overlap", {30'd0, x_ready_o, h_ready_o}, 32'd0);
      if (y_valid_o && y_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          check("y_data", y_data_o, exp_q.pop_front());
        end
        got_q.push_back(y_data_o);
      end
    end
  end

  task automatic pin(input int idx, input logic [31:0] lit);
    check($sformatf("pin_y%0d", idx), (got_q.size() > idx) ? got_q[idx] : 32'hxxxx_xxxx, lit);
  endtask

  task automatic start_job(input int len, input int nb, input int sh, input bit simple);
    len_i = CNT_W'(len); nb_iter_i = CNT_W'(nb); shift_i = 5'(sh); simple_mul_i = simple;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic feed(input int first, input int n);
    int  i = first;
    int  budget = 0;
    bit  fired;
    while (i < first + n && budget < 100 * n + 100) begin
      x_valid_i = 1'b1; h_valid_i = 1'b1;
      x_data_i = 16'(xq[i]); h_data_i = 16'(hq[i]);
      @(negedge clk_i);
      fired = x_ready_o && h_ready_o;
      @(posedge clk_i); #1;
      if (fired) i++;
      budget++;
    end
    x_valid_i = 1'b0; h_valid_i = 1'b0;
    check("feed_complete", i, first + n);
  endtask

  task automatic backpressure();
    int t = 0;
    logic [31:0] held;
    while (!y_valid_o && t < 200) begin @(negedge clk_i); t++; end
    check("bp_valid_seen", {31'd0, y_valid_o}, 32'd1);
    held = y_data_o;
    repeat (5) begin
      @(negedge clk_i);
      check("bp_valid_held", {31'd0, y_valid_o}, 32'd1);
      check("bp_data_stable", y_data_o, held);
      check("bp_ready_low", {30'd0, x_ready_o, h_ready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    y_ready_i = 1'b1;
  endtask

  task automatic run_job(input int len, input int nb, input int sh, input bit simple,
                         input int nwords, input bit toggle, input bit bp);
    int t = 0;
    model(len, nb, sh, simple);
    got_q.delete();
    done_cnt = 0;
    if (bp) y_ready_i = 1'b0;
    start_job(len, nb, sh, simple);
    if (toggle) begin
      for (int k = 0; k < 4; k++) begin
        h_valid_i = 1'b0; x_valid_i = k[0]; x_data_i = 16'h1234;
        @(negedge clk_i);
        check("toggle_x_ready", {31'd0, x_ready_o}, 32'd0);
        check("toggle_no_fire", {31'd0, y_valid_o}, 32'd0);
        @(posedge clk_i); #1;
      end
    end
    fork
      feed(0, nwords);
      if (bp) backpressure();
    join
    while (done_cnt == 0 && t < 400) begin @(posedge clk_i); t++; end
    check("done_seen", {31'd0, done_cnt > 0}, 32'd1);
    @(negedge clk_i);
    check("busy_after_done", {31'd0, busy_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check("done_pulses", done_cnt, 1);
    check("exp_drained", exp_q.size(), 0);
    check("outputs_seen", got_q.size(), nb);
  endtask

  initial begin
    #2;
    check("rst_y_valid", {31'd0, y_valid_o}, 32'd0);
    check("rst_y_data", y_data_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    xq = '{1, 2, 3, 4, 5, 6}; hq = '{1, 1, 1, 1, 1, 1};
    run_job(3, 2, 0, 1'b0, 6, 1'b0, 1'b0);
    pin(0, 32'd6); pin(1, 32'd15);

    xq = '{16, 32, -48}; hq = '{2, 2, 2};
    run_job(7, 3, 4, 1'b1, 3, 1'b0, 1'b0);
    pin(0, 32'd2); pin(1, 32'd4); pin(2, 32'hffff_fffa);

    xq = '{32767}; hq = '{32767};
    run_job(1, 1, 0, 1'b0, 1, 1'b0, 1'b0);
    pin(0, 32'h3fff_0001);

    xq = '{-32768, -32768}; hq = '{-32768, -32768};
    run_job(2, 1, 0, 1'b0, 2, 1'b0, 1'b0);
    pin(0, 32'h7fff_ffff);

    xq = '{-32768, -32768, -32768, -32768}; hq = '{-32768, -32768, -32768, -32768};
    run_job(4, 1, 0, 1'b0, 4, 1'b0, 1'b0);
    pin(0, 32'h7fff_ffff);

    xq = '{-32768, -32768, -32768, -32768}; hq = '{32767, 32767, 32767, 32767};
    run_job(4, 1, 0, 1'b0, 4, 1'b0, 1'b0);
    pin(0, 32'h8000_0000);

    // len=0 acts as one tap; shift 31 leaves only the sign.
    xq = '{-1, 5}; hq = '{1, 7};
    run_job(0, 2, 31, 1'b0, 2, 1'b0, 1'b0);
    pin(0, 32'hffff_ffff); pin(1, 32'd0);

    xq = '{3, 4, 5, 6}; hq = '{10, 10, -1, -1};
    run_job(2, 2, 0, 1'b0, 4, 1'b0, 1'b1);
    pin(0, 32'd70); pin(1, 32'hffff_fff5);

    xq = '{9}; hq = '{-3};
    run_job(1, 1, 0, 1'b0, 1, 1'b1, 1'b0);
    pin(0, 32'hffff_ffe5);

    // Asynchronous reset after two of four taps.
    xq = '{100, 100, 100, 100}; hq = '{100, 100, 100, 100};
    start_job(4, 1, 0, 1'b0);
    feed(0, 2);
    #2 rst_i = 1'b1;
    #1;
    check("arst_y_valid", {31'd0, y_valid_o}, 32'd0);
    check("arst_y_data", y_data_o, 32'd0);
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_done", {31'd0, done_o}, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    x_valid_i = 1'b1; h_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("arst_needs_start", {30'd0, x_ready_o, h_ready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    x_valid_i = 1'b0; h_valid_i = 1'b0;
    xq = '{1, 2, 3, 4}; hq = '{1, 1, 1, 1};
    run_job(4, 1, 0, 1'b0, 4, 1'b0, 1'b0);
    pin(0, 32'd10);

    // nb_iter=0: straight to DONE with no stream handshake.
    done_cnt = 0;
    x_valid_i = 1'b1; h_valid_i = 1'b1;
    start_job(5, 0, 0, 1'b0);
    @(negedge clk_i);
    check("nb0_done_high", {31'd0, done_o}, 32'd1);
    check("nb0_busy", {31'd0, busy_o}, 32'd1);
    check("nb0_no_ready", {30'd0, x_ready_o, h_ready_o}, 32'd0);
    @(negedge clk_i);
    check("nb0_done_low", {31'd0, done_o}, 32'd0);
    check("nb0_no_ready2", {30'd0, x_ready_o, h_ready_o}, 32'd0);
    check("nb0_pulses", done_cnt, 1);
    @(posedge clk_i); #1;
    x_valid_i = 1'b0; h_valid_i = 1'b0;

    // Soft clear while an output is pending.
    xq = '{2, 3}; hq = '{4, 5};
    y_ready_i = 1'b0;
    start_job(2, 1, 0, 1'b0);
    feed(0, 2);
    begin
      int t = 0;
      while (!y_valid_o && t < 50) begin @(negedge clk_i); t++; end
    end
    check("clr_pending_y", y_data_o, 32'd23);
    @(posedge clk_i); #1;
    clear_i = 1'b1; start_i = 1'b1; x_valid_i = 1'b1; h_valid_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    check("clr_y_valid", {31'd0, y_valid_o}, 32'd0);
    check("clr_y_data", y_data_o, 32'd0);
    check("clr_busy", {31'd0, busy_o}, 32'd0);
    check("clr_no_ready", {30'd0, x_ready_o, h_ready_o}, 32'd0);
    x_valid_i = 1'b0; h_valid_i = 1'b0; y_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
